// File: rtl/oa_div_pkg.sv
// Shared constants for the restoring-division datapath: control-word bit
// positions, condition-vector bit positions and the reset value of p.
package oa_div_pkg;

  localparam int Y_LOAD_A    = 0;
  localparam int Y_LOAD_B    = 1;
  localparam int Y_SHIFT     = 2;
  localparam int Y_CNT_LOAD  = 3;
  localparam int Y_SUB       = 4;
  localparam int Y_ADD       = 5;
  localparam int Y_SET_Q     = 6;
  localparam int Y_CNT_DEC   = 7;
  localparam int Y_SET_OVF   = 8;
  localparam int Y_SET_ERR   = 9;
  localparam int Y_SET_DONE  = 10;
  localparam int Y_CLR_FLAGS = 11;

  localparam int P_B_NZ   = 0;
  localparam int P_NEG    = 1;
  localparam int P_CNT_Z  = 2;
  localparam int P_RR_Z   = 3;
  localparam int P_Q0     = 4;
  localparam int P_OVF    = 5;
  localparam int P_ERR    = 6;
  localparam int P_Q_LT_B = 7;
  localparam int P_DONE   = 8;
  localparam int P_START  = 9;

  // With every register cleared only CNT==0 and RR==0 are true.
  localparam logic [9:0] P_RESET = 10'h00C;

endpackage

// File: rtl/oa_div_datapath_if.sv
// Bus between the microprogrammed controller/environment and the division
// datapath: operands, control word in, condition vector and results out.
interface oa_div_datapath_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] din_a;
  logic [N-1:0] din_b;
  logic [11:0]  y;
  logic [9:0]   p;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         done;

  modport master (
    output start, din_a, din_b, y,
    input  p, quotient, remainder, done
  );

  modport slave (
    input  start, din_a, din_b, y,
    output p, quotient, remainder, done
  );
endinterface

// File: rtl/oa_addsub.sv
// Combinational (N+1)-bit add/subtract of the remainder and the zero-extended
// divisor; passes RR through unchanged when neither operation is requested.
module oa_addsub #(
  parameter int N = 8
) (
  input  logic [N:0]   rr,
  input  logic [N-1:0] rb,
  input  logic         sub,
  input  logic         add,
  output logic [N:0]   res
);
  logic [N:0] rb_ext;

  assign rb_ext = {1'b0, rb};

  // Subtract outranks add when both are requested.
  always_comb begin
    res = rr;
    if (sub) begin
      res = rr - rb_ext;
    end else if (add) begin
      res = rr + rb_ext;
    end else begin
      res = rr;
    end
  end
endmodule

// File: rtl/oa_div_datapath.sv
// Operational automaton for N-bit unsigned restoring division: holds RB, RR,
// RQ, CNT and the flags, executes control word y, reports condition vector p.
module oa_div_datapath
  import oa_div_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = $clog2(N + 1)
) (
  input logic              clk,
  input logic              rst,
  oa_div_datapath_if.slave bus
);
  logic [N-1:0]  rb;
  logic [N:0]    rr;
  logic [N-1:0]  rq;
  logic [CW-1:0] cnt;
  logic          ovf;
  logic          err;
  logic          done_flag;
  logic          start_r;
  logic [N:0]    rr_arith;
  logic [11:0]   y;
  logic [9:0]    p_vec;

  assign y = bus.y;

  oa_addsub #(.N(N)) u_addsub (
    .rr  (rr),
    .rb  (rb),
    .sub (y[Y_SUB]),
    .add (y[Y_ADD]),
    .res (rr_arith)
  );

  // Register file update; all right-hand sides use pre-edge register values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rb        <= '0;
      rr        <= '0;
      rq        <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      err       <= 1'b0;
      done_flag <= 1'b0;
      start_r   <= 1'b0;
    end else begin
      start_r <= bus.start;

      if (y[Y_LOAD_B]) begin
        rb <= bus.din_b;
      end

      if (y[Y_LOAD_A]) begin
        rq <= bus.din_a;
        rr <= '0;
      end else if (y[Y_SHIFT]) begin
        rr <= {rr[N-1:0], rq[N-1]};
        rq <= {rq[N-2:0], 1'b0};
      end else begin
        rr <= rr_arith;
        if (y[Y_SET_Q]) begin
          rq[0] <= 1'b1;
        end
      end

      // Counter saturates at zero so a stray decrement cannot wrap it.
      if (y[Y_CNT_LOAD]) begin
        cnt <= CW'(N);
      end else if (y[Y_CNT_DEC] && (cnt != '0)) begin
        cnt <= cnt - CW'(1);
      end

      if (y[Y_CLR_FLAGS]) begin
        ovf       <= 1'b0;
        err       <= 1'b0;
        done_flag <= 1'b0;
      end else begin
        if (y[Y_SET_OVF]) begin
          ovf <= 1'b1;
        end
        if (y[Y_SET_ERR]) begin
          err <= 1'b1;
        end
        if (y[Y_SET_DONE]) begin
          done_flag <= 1'b1;
        end
      end
    end
  end

  // Condition vector decoded straight from the registers.
  always_comb begin
    p_vec           = 10'h000;
    p_vec[P_B_NZ]   = (rb != '0);
    p_vec[P_NEG]    = rr[N];
    p_vec[P_CNT_Z]  = (cnt == '0);
    p_vec[P_RR_Z]   = (rr == '0);
    p_vec[P_Q0]     = rq[0];
    p_vec[P_OVF]    = ovf;
    p_vec[P_ERR]    = err;
    p_vec[P_Q_LT_B] = (rq < rb);
    p_vec[P_DONE]   = done_flag;
    p_vec[P_START]  = start_r;
  end

  assign bus.p         = p_vec;
  assign bus.quotient  = rq;
  assign bus.remainder = rr[N-1:0];
  assign bus.done      = done_flag;
endmodule

// File: tb/tb_oa_div_datapath.sv
// Directed bench for oa_div_datapath acting as the controller: expectations
// are queued when a control word is driven and checked after the clock edge.
module tb_oa_div_datapath;
  import oa_div_pkg::*;

  localparam int N = 8;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;
  exp_t sb[$];

  oa_div_datapath_if #(.N(N)) bus ();

  oa_div_datapath #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // sel: 0 quotient, 1 remainder, 2 done, 3 whole p, 4+k bit k of p
  function automatic logic [31:0] observe(input int sel);
    case (sel)
      0:       observe = 32'(bus.quotient);
      1:       observe = 32'(bus.remainder);
      2:       observe = 32'(bus.done);
      3:       observe = 32'(bus.p);
      default: observe = (sel >= 4 && sel < 14) ? 32'(bus.p[sel-4]) : 32'hxxxxxxxx;
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      n_assert++;
      assert (obs === e.exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
      end
    end
  endtask

  // Drive a control word for one edge, then check everything queued for it.
  task automatic apply(input logic [11:0] yv);
    bus.y = yv;
    @(posedge clk);
    #1;
    bus.y = 12'h000;
    drain();
  endtask

  task automatic divide(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N:0]   m_rr;
    logic [N-1:0] m_rq;
    logic [2*N:0] sh;
    bus.din_a = a;
    bus.din_b = b;
    push("load_q", 0, 32'(a));
    push("load_done_clr", 2, 32'd0);
    apply(12'h803);
    apply(12'h008);
    m_rr = '0;
    m_rq = a;
    for (int i = 0; i < N; i++) begin
      apply(12'h004);
      sh   = {m_rr[N-1:0], m_rq, 1'b0};
      m_rr = sh[2*N:N];
      m_rq = sh[N-1:0];
      m_rr = m_rr - {1'b0, b};
      push($sformatf("neg_it%0d", i), 4 + P_NEG, 32'(m_rr[N]));
      apply(12'h010);
      if (m_rr[N]) begin
        m_rr = m_rr + {1'b0, b};
        apply(12'h020);
      end else begin
        m_rq[0] = 1'b1;
        apply(12'h040);
      end
      apply(12'h080);
    end
    push("cnt_zero_end", 4 + P_CNT_Z, 32'd1);
    push("done_before", 4 + P_DONE, 32'd0);
    apply(12'h000);
    push("div_quotient", 0, 32'(a / b));
    push("div_remainder", 1, 32'(a % b));
    push("div_p8", 4 + P_DONE, 32'd1);
    push("div_done", 2, 32'd1);
    apply(12'h400);
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.din_a = '0;
    bus.din_b = '0;
    bus.y     = 12'h000;
    #12;
    push("rst_p", 3, 32'(P_RESET));
    push("rst_q", 0, 32'd0);
    drain();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset in the middle of an operation acts without a clock edge.
    bus.din_a = 8'd200;
    push("pre_rst_q", 0, 32'd200);
    apply(12'h001);
    rst = 1'b1;
    #1;
    push("mid_rst_q", 0, 32'd0);
    push("mid_rst_r", 1, 32'd0);
    push("mid_rst_done", 2, 32'd0);
    push("mid_rst_p", 3, 32'(P_RESET));
    drain();
    @(posedge clk);
    #1;
    rst = 1'b0;

    bus.start = 1'b1;
    push("start_hi", 4 + P_START, 32'd1);
    apply(12'h000);
    bus.start = 1'b0;
    push("start_lo", 4 + P_START, 32'd0);
    apply(12'h000);

    bus.din_a = 8'd200;
    bus.din_b = 8'd7;
    push("ld_q", 0, 32'd200);
    push("ld_r", 1, 32'd0);
    push("ld_b_nz", 4 + P_B_NZ, 32'd1);
    push("ld_q_lt_b", 4 + P_Q_LT_B, 32'd0);
    push("ld_rr_z", 4 + P_RR_Z, 32'd1);
    apply(12'h003);
    push("hold_q", 0, 32'd200);
    apply(12'h000);

    divide(8'd200, 8'd7);
    push("sat_cnt", 4 + P_CNT_Z, 32'd1);
    push("sat_q_hold", 0, 32'd28);
    apply(12'h080);
    divide(8'd255, 8'd1);
    divide(8'd13, 8'd200);

    bus.din_b = 8'd0;
    apply(12'h002);
    push("err_b_nz", 4 + P_B_NZ, 32'd0);
    push("err_set", 4 + P_ERR, 32'd1);
    apply(12'h200);
    push("err_clr", 4 + P_ERR, 32'd0);
    push("done_clr", 2, 32'd0);
    apply(12'h800);
    push("ovf_set", 4 + P_OVF, 32'd1);
    apply(12'h100);
    push("ovf_clr_wins", 4 + P_OVF, 32'd0);
    apply(12'h900);

    // Sub and add together: subtract wins, RR wraps modulo 2^(N+1).
    bus.din_a = 8'd5;
    bus.din_b = 8'd3;
    apply(12'h003);
    push("subadd_r", 1, 32'h0FD);
    push("subadd_neg", 4 + P_NEG, 32'd1);
    apply(12'h030);
    push("shift_q", 0, 32'h00A);
    push("shift_q0", 4 + P_Q0, 32'd0);
    push("shift_r", 1, 32'h0FA);
    apply(12'h044);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/oa_div_datapath.md
Name: oa_div_datapath

Overview:
- Operational (datapath) automaton paired with the microprogrammed control automaton.
- Executes an N-bit unsigned restoring division step by step.
- Takes the 12-bit control word y from the controller and returns the 10-bit condition vector p that the controller branches on.
- Holds the divisor, remainder and quotient registers, the iteration counter and the status flags.

Parameters:
N, 8, operand width in bits (N >= 2)
CW, $clog2(N+1), iteration counter width

Ports:
clk  in  1  clock; wired to the controller's clkout, so the datapath updates half a cycle after the controller
rst  in  1  asynchronous, active-high reset
start  in  1  operation request from the environment
din_a  in  N  dividend
din_b  in  N  divisor
y  in  12  control word from the controller
p  out  10  condition vector to the controller
quotient  out  N  RQ register
remainder  out  N  RR[N-1:0]
done  out  1  DONE flag register

Behaviour:
- One clock, clk. Reset is asynchronous and active-high on rst. All registers update on the rising edge of clk.
- Registers: RB[N-1:0]; RR[N:0] (remainder, MSB is sign); RQ[N-1:0]; CNT[CW-1:0]; flags OVF, ERR, DONE; START_R.
- Reset clears every register to 0.
  - Reset values: quotient=0, remainder=0, done=0, p=10'h00C.
  - Reset mid-operation aborts the operation immediately. No partial result is retained.

Control bits (1 = active), applied in a single clock edge:
- y0: RQ<=din_a, RR<=0.
- y1: RB<=din_b.
- y2: {RR,RQ} <= {RR[N-1:0],RQ,1'b0} (shift left 1).
- y3: CNT<=N.
- y4: RR<=RR-{1'b0,RB}, mod 2^(N+1).
- y5: RR<=RR+{1'b0,RB}, mod 2^(N+1).
- y6: RQ[0]<=1.
- y7: CNT<=CNT-1. Saturates at 0, never wraps.
- y8: OVF<=1.
- y9: ERR<=1.
- y10: DONE<=1.
- y11: OVF, ERR and DONE <= 0.

Priorities for simultaneous bits:
- RR: y0 > y2 > y4 > y5. A lower-priority bit is ignored when a higher one is set.
- RQ: y0 > y2 > y6. When y2 and y6 are both set, the shift occurs and y6 is ignored.
- Flags: y11 > y8/y9/y10 (clear wins).
- All arithmetic uses pre-edge register values. The result is visible on p one cycle after the control word.

Condition vector (p is combinational from registers, no extra latency):
- p0 = (RB != 0)
- p1 = RR[N] (negative after subtract)
- p2 = (CNT == 0)
- p3 = (RR == 0)
- p4 = RQ[0]
- p5 = OVF
- p6 = ERR
- p7 = (RQ < RB) (dividend smaller than divisor)
- p8 = DONE
- p9 = START_R, where START_R <= start every cycle (1-cycle registered copy)

Other rules:
- done = DONE. Outputs are stable until the next y0 or y11.
- y = 0 holds all state. Undefined y encodings never corrupt state beyond the rules above.

Decomposition:
- Package oa_div_pkg holds:
  - localparams for control bit indices Y_LOAD_A=0 … Y_CLR_FLAGS=11;
  - localparams for condition indices P_B_NZ=0 … P_START=9;
  - the reset constant P_RESET=10'h00C.
- One natural sub-module: oa_addsub.
  - Combinational (N+1)-bit add/subtract of RR and zero-extended RB, selected by y4/y5.
  - Instantiated once. All registers stay in the top module.

Test Plan:
- Assert rst mid-sequence (after y0 with din_a=200) -> quotient=0, remainder=0, done=0, p=10'h00C immediately, without waiting for a clock edge.
- Raise start=1 for one cycle -> p9=1 exactly one edge later, 0 the edge after.
- Load y=12'h003 with din_a=200, din_b=7 -> next edge RQ=200, RB=7, RR=0, p0=1, p7=0, p3=1.
- Full restoring loop for N=8: y3, then 8 × {y2; y4; if p1 then y5 else y6; y7}, then y10 on p2=1 -> quotient=28, remainder=4, p8=1. Repeat for 255/1 -> 255, 0.
- din_b=0 with y1, then y9 -> p0=0, p6=1. A following y11 clears p6. A cycle with y8 and y11 both set leaves p5=0.
- Priority/boundary checks:
  - y4 and y5 together with RR=0, RB=3 -> RR=2^(N+1)-3, p1=1.
  - y7 with CNT=0 -> CNT stays 0, p2=1.
  - y2 with y6 -> RQ[0]=0.
